// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - wfifo write port and receive status bundle for uart_rx
interface uart_rx_if;
  logic       wfifo_wr_en;
  logic [7:0] wfifo_wr_data;
  logic       wfifo_full;
  logic       rx_busy;
  logic       frame_err;
  logic       overrun;

  modport master (
    output wfifo_wr_en, wfifo_wr_data, rx_busy, frame_err, overrun,
    input  wfifo_full
  );

  modport slave (
    input  wfifo_wr_en, wfifo_wr_data, rx_busy, frame_err, overrun,
    output wfifo_full
  );
endinterface

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 serial receiver feeding the SDRAM write-side FIFO
module uart_rx #(
  parameter int BAUD_END = 5208,
  parameter int BAUD_MID = BAUD_END / 2,
  parameter int CNT1_END = 10
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      rs232_rx,
  uart_rx_if.master bus
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state, next_state;
  logic        rx_r1, rx_r2, rx_r3;
  logic [12:0] cnt0;
  logic [3:0]  cnt1;
  logic [7:0]  shreg;
  logic        fall, sample, wrap;
  logic        do_shift, do_write, do_ferr, do_ovr;

  assign fall   = rx_r3 & ~rx_r2;
  assign sample = (cnt0 == 13'(BAUD_MID - 1));
  assign wrap   = (cnt0 == 13'(BAUD_END - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (fall) next_state = START;
      START: begin
        if (sample && rx_r2)  next_state = IDLE;
        else if (wrap)        next_state = DATA;
      end
      DATA:  if (wrap && cnt1 == 4'(CNT1_END - 2)) next_state = STOP;
      STOP:  if (sample) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Stop bit resolves at its sample point so the next start edge is never missed
  always_comb begin
    do_shift = 1'b0;
    do_write = 1'b0;
    do_ferr  = 1'b0;
    do_ovr   = 1'b0;
    case (state)
      DATA: do_shift = sample;
      STOP: begin
        if (sample) begin
          if (!rx_r2)                 do_ferr  = 1'b1;
          else if (bus.wfifo_full)    do_ovr   = 1'b1;
          else                        do_write = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_r1             <= 1'b1;
      rx_r2             <= 1'b1;
      rx_r3             <= 1'b1;
      cnt0              <= '0;
      cnt1              <= '0;
      shreg             <= '0;
      bus.wfifo_wr_en   <= 1'b0;
      bus.wfifo_wr_data <= 8'h00;
      bus.rx_busy       <= 1'b0;
      bus.frame_err     <= 1'b0;
      bus.overrun       <= 1'b0;
    end else begin
      rx_r1 <= rs232_rx;
      rx_r2 <= rx_r1;
      rx_r3 <= rx_r2;
      if (state == IDLE) begin
        cnt0 <= '0;
        cnt1 <= '0;
      end else if (wrap) begin
        cnt0 <= '0;
        cnt1 <= cnt1 + 4'd1;
      end else begin
        cnt0 <= cnt0 + 13'd1;
      end
      // Data bit k (cnt1=k, 1..8) lands in shreg[k-1]; 3-bit wrap maps 8 to 7
      if (do_shift) shreg[cnt1[2:0] - 3'd1] <= rx_r2;
      bus.wfifo_wr_en <= do_write;
      if (do_write) bus.wfifo_wr_data <= shreg;
      bus.frame_err   <= do_ferr;
      bus.overrun     <= do_ovr;
      bus.rx_busy     <= (state != IDLE);
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx with a frame-level event model
module tb_uart_rx;
  localparam int BE  = 16;
  localparam int BM  = 8;
  localparam int LAT = 9 * BE + BM + 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rs232_rx = 1'b1;
  int unsigned cyc = 0;

  uart_rx_if bus();

  uart_rx #(.BAUD_END(BE), .BAUD_MID(BM), .CNT1_END(10)) dut (
    .clk(clk),
    .rst(rst),
    .rs232_rx(rs232_rx),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [1:0]  kind;
    logic [7:0]  data;
    logic [31:0] at;
  } ev_t;

  ev_t got[$];
  ev_t exp_q[$];
  int n_assert = 0;
  int n_fail = 0;
  int busy_cnt = 0;
  logic prev_wr = 1'b0;

  always @(negedge clk) begin
    if (bus.wfifo_wr_en) begin
      got.push_back(ev_t'{kind: 2'd0, data: bus.wfifo_wr_data, at: cyc});
      n_assert++;
      assert (prev_wr === 1'b0) else begin
        n_fail++;
        $error("FAIL wr_en_consecutive: observed %0b expected 0", prev_wr);
      end
    end
    if (bus.frame_err) got.push_back(ev_t'{kind: 2'd1, data: 8'h00, at: cyc});
    if (bus.overrun)   got.push_back(ev_t'{kind: 2'd2, data: 8'h00, at: cyc});
    if (bus.rx_busy)   busy_cnt++;
    prev_wr = bus.wfifo_wr_en;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wr_en"},   32'(bus.wfifo_wr_en),   32'd0);
    chk({tag, "_wr_data"}, 32'(bus.wfifo_wr_data), 32'd0);
    chk({tag, "_busy"},    32'(bus.rx_busy),       32'd0);
    chk({tag, "_ferr"},    32'(bus.frame_err),     32'd0);
    chk({tag, "_ovr"},     32'(bus.overrun),       32'd0);
  endtask

  // Model: a complete frame yields one event LAT cycles after its start bit begins
  task automatic send_frame(input logic [7:0] b, input logic stopb, input logic full,
                            input int gap, input int rst_bit);
    logic [9:0] bits;
    logic aborted;
    int unsigned start;
    bits = {stopb, b, 1'b0};
    aborted = 1'b0;
    bus.wfifo_full = full;
    start = cyc;
    if (rst_bit < 0) begin
      if (!stopb)    exp_q.push_back(ev_t'{kind: 2'd1, data: 8'h00, at: start + LAT});
      else if (full) exp_q.push_back(ev_t'{kind: 2'd2, data: 8'h00, at: start + LAT});
      else           exp_q.push_back(ev_t'{kind: 2'd0, data: b,     at: start + LAT});
    end
    for (int i = 0; i < 10 && !aborted; i++) begin
      rs232_rx = bits[i];
      for (int j = 0; j < BE && !aborted; j++) begin
        if (i == rst_bit && j == 4) rst = 1'b1;
        @(posedge clk);
        #1;
        if (rst) begin
          rst = 1'b0;
          aborted = 1'b1;
          chk_reset_outputs("midframe_rst");
        end
      end
    end
    rs232_rx = 1'b1;
    bus.wfifo_full = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_events(input string tag);
    int n;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
    n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
    for (int k = 0; k < n; k++) begin
      chk({tag, "_kind"}, 32'(got[k].kind), 32'(exp_q[k].kind));
      chk({tag, "_data"}, 32'(got[k].data), 32'(exp_q[k].data));
      chk({tag, "_cycle"}, got[k].at, exp_q[k].at);
    end
    got.delete();
    exp_q.delete();
  endtask

  initial begin
    bus.wfifo_full = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end

    send_frame(8'hA5, 1'b1, 1'b0, 10, -1);
    check_events("single_a5");

    send_frame(8'h00, 1'b1, 1'b0, 0, -1);
    send_frame(8'hFF, 1'b1, 1'b0, 0, -1);
    send_frame(8'h3C, 1'b1, 1'b0, 10, -1);
    check_events("back_to_back");

    send_frame(8'h55, 1'b0, 1'b0, 3, -1);
    send_frame(8'h81, 1'b1, 1'b0, 10, -1);
    check_events("framing");

    busy_cnt = 0;
    rs232_rx = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    rs232_rx = 1'b1;
    repeat (40) begin
      @(posedge clk);
      #1;
    end
    chk("glitch_busy_cycles", 32'(busy_cnt), 32'(BM));
    check_events("glitch");

    send_frame(8'h12, 1'b1, 1'b1, 5, -1);
    send_frame(8'h34, 1'b1, 1'b0, 10, -1);
    check_events("overrun");

    send_frame(8'h99, 1'b1, 1'b0, 20, 5);
    send_frame(8'h42, 1'b1, 1'b0, 10, -1);
    check_events("rst_midframe");

    for (int r = 0; r < 10; r++) begin
      logic [7:0] b;
      logic stopb;
      logic full;
      int gap;
      b = 8'($urandom);
      stopb = ($urandom_range(0, 3) != 0);
      full = ($urandom_range(0, 3) == 0);
      gap = stopb ? int'($urandom_range(0, 12)) : int'($urandom_range(2, 12));
      send_frame(b, stopb, full, gap, -1);
    end
    check_events("random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
